cnn_window_ctrl: RTL and testbench
==================================

# cnn_window_ctrl

Frame-scan controller for the CNN front end. It sequences raster-order reads of the 480x272 RGB888 image memory (130560 words, 17-bit address) and tags each returned pixel with its row and column. It flags which pixels complete a valid 3x3 window for the line-buffer/window generator that drives oOut0..oOut8. It honours the downstream iBusy stall and reports frame completion.

## Interface
Parameters:
- IMG_W, 480, image width in pixels
- IMG_H, 272, image height in pixels
- ADDR_W, 17, memory address width; IMG_W*IMG_H must be at most 2^ADDR_W
- RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
- iClk  in  1  clock
- iRst  in  1  reset, asynchronous, active-high
- iStart  in  1  frame start request; sampled only in IDLE
- iBusy  in  1  downstream stall; while high no new read is issued
- oRdEn  out  1  memory read enable
- oRdAddr  out  ADDR_W  memory read address
- oPixValid  out  1  memory data valid this cycle (oRdEn delayed RD_LAT)
- oCol  out  9  column of the pixel on the memory data bus
- oRow  out  9  row of the pixel on the memory data bus
- oWinValid  out  1  oPixValid and oRow>=2 and oCol>=2 (bottom-right tap of a full 3x3 window)
- oActive  out  1  high in any state other than IDLE
- oFrameDone  out  1  one-cycle pulse at end of frame

## Operation
- State machine: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE:
  - iStart=1 clears the address, column and row counters and moves to FETCH.
  - iStart=0 keeps the block in IDLE.
- FETCH:
  - oRdEn = !iBusy (combinational from the state register and iBusy).
  - oRdAddr = address counter.
  - On each cycle with oRdEn=1: address +1, column +1.
  - When the column equals IMG_W-1, the column wraps to 0 and the row increments.
  - The read of address IMG_W*IMG_H-1 moves the block to DRAIN.
- DRAIN: lasts exactly RD_LAT cycles, then moves to DONE. oRdEn is 0.
- DONE: oFrameDone=1 for this cycle only, then moves to IDLE.
- Read-return pipeline:
  - A RD_LAT-deep shift register carries {rdEn, row, col}. Its output drives oPixValid, oRow and oCol.
  - It is never stalled: data already issued returns regardless of later iBusy.
- Windows per frame: (IMG_W-2)*(IMG_H-2) = 129060 at default parameters. Pixels per frame: 130560.
- Boundary rules:
  - iStart outside IDLE is ignored.
  - iBusy has no effect in DRAIN, DONE or IDLE.
  - iBusy held high forever in FETCH freezes the counters. The block stays in FETCH with no timeout.
  - iStart held high continuously runs back-to-back frames, with one IDLE cycle between frames.
  - Reset mid-frame abandons the frame immediately; the pipeline contents are discarded.
- Reset values:
  - State IDLE; all counters 0; shift register cleared.
  - Outputs oRdEn, oPixValid, oWinValid, oActive and oFrameDone are 0; oRdAddr, oRow and oCol are 0.

## Timing
- iStart=1 in IDLE at cycle N:
  - FETCH and oActive=1 from N+1.
  - First oRdEn at N+1 with oRdAddr=0, if iBusy=0.
- Read issued at cycle K: the matching oPixValid/oRow/oCol appear at K+RD_LAT.
- Unstalled default frame, RD_LAT=1:
  - Last read (addr 130559) at N+130560.
  - DRAIN at N+130561, where the last oPixValid is seen with oRow=271 and oCol=479.
  - DONE/oFrameDone at N+130562.
  - IDLE at N+130563.
- Each iBusy-high cycle in FETCH lengthens the frame by exactly one cycle.
- Total frame: IMG_W*IMG_H + (iBusy-high cycles in FETCH) + RD_LAT + 1 cycles from FETCH entry to DONE inclusive.

## Test plan
- Reset: hold iRst=1 with iStart=1 -> all outputs 0, state IDLE. After release, iStart=1 at N -> oRdEn=1 and oRdAddr=0 at N+1.
- Small config (IMG_W=5, IMG_H=4, RD_LAT=1), no stall:
  - Expect 20 reads with addresses 0..19 and 20 oPixValid.
  - Expect 6 oWinValid, at (row,col) = (2,2),(2,3),(2,4),(3,2),(3,3),(3,4).
  - oFrameDone exactly 22 cycles after the first oRdEn.
- Stall: small config with iBusy=1 on cycles 3-5 of FETCH:
  - oRdAddr holds at 2 and oRdEn=0 for those 3 cycles.
  - A read already issued still returns.
  - oFrameDone is delayed by exactly 3 cycles.
- Latency: RD_LAT=3, small config -> oPixValid trails oRdEn by 3 cycles; DRAIN lasts 3 cycles; oFrameDone 24 cycles after the first oRdEn.
- Abort and restart: assert iRst at pixel 10 of a frame -> outputs cleared immediately. A new iStart replays from addr 0 with a correct full count; iStart pulses during FETCH are ignored.
- Default config: full 480x272 frame -> 130560 oPixValid, 129060 oWinValid, last pixel (271,479), one oFrameDone pulse.

Source files
------------

// File: rtl/cnn_window_ctrl.sv
// Raster-scan read sequencer for the CNN front end: issues frame reads, tags the
// returned pixels with row/column and flags the bottom-right tap of each full 3x3 window.
module cnn_window_ctrl #(
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 272,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iBusy,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oPixValid,
  output logic [8:0]        oCol,
  output logic [8:0]        oRow,
  output logic              oWinValid,
  output logic              oActive,
  output logic              oFrameDone
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [8:0]        LAST_COL   = 9'(IMG_W - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [8:0]          r_col;
  logic [8:0]          r_row;
  logic [2:0]          r_drainCnt;
  logic                r_active;
  logic                r_frameDone;
  logic [RD_LAT-1:0]       r_pipeVld;
  logic [RD_LAT-1:0][8:0]  r_pipeRow;
  logic [RD_LAT-1:0][8:0]  r_pipeCol;
  logic                w_rdEn;

  // The stall has to gate the read in the same cycle, so this is the one combinational output.
  assign w_rdEn = (r_state == FETCH) && !iBusy;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_drainCnt  <= '0;
      r_active    <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iStart) begin
            r_addr   <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b1;
            r_state  <= FETCH;
          end
        end
        FETCH: begin
          if (w_rdEn) begin
            r_addr <= r_addr + 1'b1;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 9'd1;
            end else begin
              r_col <= r_col + 9'd1;
            end
            if (r_addr == LAST_ADDR) begin
              r_drainCnt <= '0;
              r_state    <= DRAIN;
            end
          end
        end
        // Wait out the reads still in flight before declaring the frame finished.
        DRAIN: begin
          if (r_drainCnt == LAST_DRAIN) begin
            r_frameDone <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_drainCnt <= r_drainCnt + 3'd1;
          end
        end
        DONE: begin
          r_frameDone <= 1'b0;
          r_active    <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Mirrors the memory latency; never stalls because the memory cannot hold returned data.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_pipeVld <= '0;
      r_pipeRow <= '0;
      r_pipeCol <= '0;
    end else begin
      r_pipeVld[0] <= w_rdEn;
      r_pipeRow[0] <= r_row;
      r_pipeCol[0] <= r_col;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipeVld[i] <= r_pipeVld[i-1];
        r_pipeRow[i] <= r_pipeRow[i-1];
        r_pipeCol[i] <= r_pipeCol[i-1];
      end
    end
  end

  assign oRdEn      = w_rdEn;
  assign oRdAddr    = r_addr;
  assign oPixValid  = r_pipeVld[RD_LAT-1];
  assign oRow       = r_pipeRow[RD_LAT-1];
  assign oCol       = r_pipeCol[RD_LAT-1];
  assign oWinValid  = oPixValid && (oRow >= 9'd2) && (oCol >= 9'd2);
  assign oActive    = r_active;
  assign oFrameDone = r_frameDone;

endmodule

// File: tb/tb_cnn_window_ctrl.sv
// Scoreboard bench for cnn_window_ctrl: two 5x4 instances (read latency 1 and 3) driven
// by directed frames; expected reads, pixels and frame-done pulses are queued and matched.
module tb_cnn_window_ctrl;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct {
    int dut;
    int addr;
    int cyc;
  } rd_t;

  typedef struct {
    int dut;
    int row;
    int col;
    int win;
    int cyc;
  } pix_t;

  typedef struct {
    int dut;
    int cyc;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst;
  logic [1:0]  start;
  logic [1:0]  busy;
  wire  [1:0]  rdEn;
  wire  [1:0]  pixValid;
  wire  [1:0]  winValid;
  wire  [1:0]  active;
  wire  [1:0]  frameDone;
  wire  [16:0] rdAddr [2];
  wire  [8:0]  row [2];
  wire  [8:0]  col [2];

  cnn_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(17), .RD_LAT(1)) dutA (
    .iClk(clk), .iRst(rst[0]), .iStart(start[0]), .iBusy(busy[0]),
    .oRdEn(rdEn[0]), .oRdAddr(rdAddr[0]), .oPixValid(pixValid[0]),
    .oCol(col[0]), .oRow(row[0]), .oWinValid(winValid[0]),
    .oActive(active[0]), .oFrameDone(frameDone[0])
  );

  cnn_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(17), .RD_LAT(3)) dutB (
    .iClk(clk), .iRst(rst[1]), .iStart(start[1]), .iBusy(busy[1]),
    .oRdEn(rdEn[1]), .oRdAddr(rdAddr[1]), .oPixValid(pixValid[1]),
    .oCol(col[1]), .oRow(row[1]), .oWinValid(winValid[1]),
    .oActive(active[1]), .oFrameDone(frameDone[1])
  );

  rd_t   addrQ[$];
  pix_t  pixQ[$];
  done_t doneQ[$];

  int checks = 0;
  int failures = 0;
  int pixCnt[2];
  int winCnt[2];
  int doneCnt[2];
  int firstRd[2];
  int frameLen[2];
  int lastRow[2];
  int lastCol[2];
  bit seenRd[2];

  function automatic void check(int d, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", d, name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(int d, string name);
    checks++;
    failures++;
    $display("[TB] FAIL dut%0d %s: output seen with nothing expected (cycle %0d)", d, name, cyc);
  endfunction

  // Queue the raster-order reads, returned pixels and done pulse one frame should produce.
  function automatic void pushExpected(int d, int s, int lat, int stallFrom, int stallLen,
                                       int nReads, int nPix, bit withDone);
    rd_t r;
    pix_t p;
    done_t dn;
    for (int i = 0; i < nReads; i++) begin
      r.dut  = d;
      r.addr = i;
      r.cyc  = s + 1 + i + ((stallLen > 0 && i >= stallFrom - 1) ? stallLen : 0);
      addrQ.push_back(r);
      if (i < nPix) begin
        p.dut = d;
        p.row = i / W;
        p.col = i % W;
        p.win = (p.row >= 2 && p.col >= 2) ? 1 : 0;
        p.cyc = r.cyc + lat;
        pixQ.push_back(p);
      end
    end
    if (withDone) begin
      dn.dut = d;
      dn.cyc = s + 1 + W * H + stallLen + lat;
      doneQ.push_back(dn);
    end
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rd_t r;
      pix_t p;
      done_t dn;
      if (rdEn[d] === 1'b1) begin
        if (!seenRd[d]) begin
          seenRd[d]  = 1'b1;
          firstRd[d] = cyc;
        end
        if (addrQ.size() == 0) unexpected(d, "read");
        else begin
          r = addrQ.pop_front();
          check(d, "read dut", d, r.dut);
          check(d, "read addr", rdAddr[d], r.addr);
          check(d, "read cycle", cyc, r.cyc);
        end
      end
      check(d, "win without pix", winValid[d] & ~pixValid[d], 0);
      if (pixValid[d] === 1'b1) begin
        pixCnt[d]++;
        if (winValid[d] === 1'b1) winCnt[d]++;
        lastRow[d] = row[d];
        lastCol[d] = col[d];
        if (pixQ.size() == 0) unexpected(d, "pixel");
        else begin
          p = pixQ.pop_front();
          check(d, "pix dut", d, p.dut);
          check(d, "pix row", row[d], p.row);
          check(d, "pix col", col[d], p.col);
          check(d, "pix win", winValid[d], p.win);
          check(d, "pix cycle", cyc, p.cyc);
        end
      end
      if (frameDone[d] === 1'b1) begin
        doneCnt[d]++;
        frameLen[d] = cyc - firstRd[d] + 1;
        seenRd[d]   = 1'b0;
        if (doneQ.size() == 0) unexpected(d, "frame done");
        else begin
          dn = doneQ.pop_front();
          check(d, "done dut", d, dn.dut);
          check(d, "done cycle", cyc, dn.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input int d);
    check(d, "idle rdEn", rdEn[d], 0);
    check(d, "idle rdAddr", rdAddr[d], 0);
    check(d, "idle pixValid", pixValid[d], 0);
    check(d, "idle winValid", winValid[d], 0);
    check(d, "idle active", active[d], 0);
    check(d, "idle frameDone", frameDone[d], 0);
    check(d, "idle row", row[d], 0);
    check(d, "idle col", col[d], 0);
  endtask

  // One frame on instance d; optional stall window, mid-frame reset, or a stray iStart pulse.
  task automatic applyStimulus(input int d, input int stallFrom, input int stallLen,
                               input int abortAt, input int pulseAt, input int expLen);
    int s;
    int lat;
    int dones;
    lat = (d == 0) ? 1 : 3;
    @(posedge clk); #1;
    s = cyc;
    pixCnt[d] = 0;
    winCnt[d] = 0;
    seenRd[d] = 1'b0;
    dones = doneCnt[d];
    if (abortAt > 0) pushExpected(d, s, lat, 0, 0, abortAt, abortAt - lat, 1'b0);
    else             pushExpected(d, s, lat, stallFrom, stallLen, W * H, W * H, 1'b1);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int k = 1; k <= W * H + stallLen; k++) begin
      busy[d]  = (stallLen > 0 && k >= stallFrom && k < stallFrom + stallLen);
      start[d] = (k == pulseAt);
      if (abortAt > 0 && k == abortAt + 1) begin
        rst[d] = 1'b1;
        @(negedge clk);
        checkOutput(d);
        break;
      end
      @(negedge clk);
      if (busy[d]) begin
        check(d, "stall rdEn", rdEn[d], 0);
        check(d, "stall rdAddr", rdAddr[d], stallFrom - 1);
      end
      check(d, "fetch active", active[d], 1);
      @(posedge clk); #1;
    end
    busy[d]  = 1'b0;
    start[d] = 1'b0;
    if (abortAt > 0) begin
      repeat (2) @(posedge clk);
      #1;
      rst[d] = 1'b0;
      @(negedge clk);
      checkOutput(d);
      check(d, "abort pixels", pixCnt[d], 9);
    end else begin
      repeat (lat + 4) @(posedge clk);
      #1;
      check(d, "frame pixels", pixCnt[d], 20);
      check(d, "frame windows", winCnt[d], 6);
      check(d, "last row", lastRow[d], 3);
      check(d, "last col", lastCol[d], 4);
      check(d, "frame length", frameLen[d], expLen);
      check(d, "done pulses", doneCnt[d] - dones, 1);
      check(d, "active after", active[d], 0);
    end
  endtask

  initial begin
    int s;
    int dones;
    for (int d = 0; d < 2; d++) begin
      pixCnt[d] = 0; winCnt[d] = 0; doneCnt[d] = 0; firstRd[d] = 0;
      frameLen[d] = 0; lastRow[d] = 0; lastCol[d] = 0; seenRd[d] = 1'b0;
    end
    rst   = 2'b11;
    start = 2'b11;
    busy  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput(0);
    checkOutput(1);
    @(posedge clk); #1;
    rst   = 2'b00;
    start = 2'b00;

    // Busy while idle must not wake the block.
    busy[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(0, "busy idle active", active[0], 0);
    check(0, "busy idle rdEn", rdEn[0], 0);
    @(posedge clk); #1;
    busy[0] = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 22);
    applyStimulus(0, 3, 3, 0, 0, 25);
    applyStimulus(0, 0, 0, 10, 0, 0);
    applyStimulus(0, 0, 0, 0, 7, 22);
    applyStimulus(1, 0, 0, 0, 0, 24);

    // Held iStart: second frame starts after one idle cycle (done at s+24, restart sampled at s+25).
    @(posedge clk); #1;
    s = cyc;
    pixCnt[1] = 0;
    winCnt[1] = 0;
    dones = doneCnt[1];
    pushExpected(1, s, 3, 0, 0, W * H, W * H, 1'b1);
    pushExpected(1, s + 25, 3, 0, 0, W * H, W * H, 1'b1);
    start[1] = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check(1, "b2b pixels", pixCnt[1], 40);
    check(1, "b2b windows", winCnt[1], 12);
    check(1, "b2b done pulses", doneCnt[1] - dones, 2);

    check(0, "reads left", addrQ.size(), 0);
    check(0, "pixels left", pixQ.size(), 0);
    check(0, "dones left", doneQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
